// File: rtl/alu_cmd_issuer_if.sv
//==============================================================================
// Module   : alu_cmd_issuer_if
// Brief    : Command, ALU-side and response signals of alu_cmd_issuer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface alu_cmd_issuer_if #(
  parameter int CNT_W = 16
);
  // command port
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  // ALU side
  logic [31:0]      A_bus;
  logic [31:0]      B_bus;
  logic [3:0]       Control;
  logic             enable;
  logic [31:0]      C_bus;
  logic             Z_flag;
  // response port and status
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic             rsp_zero;
  logic             rsp_err;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  // Controller / ALU / consumer side
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, C_bus, Z_flag, rsp_ready,
    input  cmd_ready, A_bus, B_bus, Control, enable,
           rsp_valid, rsp_data, rsp_zero, rsp_err, busy, op_count
  );

  // The issuer itself
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, C_bus, Z_flag, rsp_ready,
    output cmd_ready, A_bus, B_bus, Control, enable,
           rsp_valid, rsp_data, rsp_zero, rsp_err, busy, op_count
  );
endinterface

`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
//==============================================================================
// Module   : alu_cmd_issuer
// Brief    : One-at-a-time command sequencer for the 32-bit convolution ALU.
//            Optional macro ALU_OPCHK_EN rejects illegal Control codes.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_cmd_issuer #(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  wire logic      clk,
  input  wire logic      reset,
  alu_cmd_issuer_if.slave bus
);

  localparam logic [3:0] c_WAIT_LOAD = 4'(ALU_LAT);
  localparam logic [3:0] c_WAIT_LAST = 4'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  logic [3:0]       r_wait_cnt;
  logic [31:0]      r_a_bus;
  logic [31:0]      r_b_bus;
  logic [3:0]       r_control;
  logic             r_enable;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_data;
  logic             r_rsp_zero;
  logic             r_busy;
  logic [CNT_W-1:0] r_op_count;
  logic             w_accept;

`ifdef ALU_OPCHK_EN
  logic r_rsp_err;
  logic w_op_legal;

  always_comb begin
    w_op_legal = 1'b0;
    case (bus.cmd_op)
      4'b0001, 4'b0010, 4'b0011, 4'b0100,
      4'b0110, 4'b1000, 4'b1001: w_op_legal = 1'b1;
      default:                   w_op_legal = 1'b0;
    endcase
  end

  assign bus.rsp_err = r_rsp_err;
`else
  assign bus.rsp_err = 1'b0;
`endif

  // Ready is masked by reset so nothing can be taken while reset is held.
  assign bus.cmd_ready = (r_state == S_IDLE) && !reset;
  assign w_accept      = bus.cmd_valid && (r_state == S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= 4'd0;
      r_a_bus     <= 32'd0;
      r_b_bus     <= 32'd0;
      r_control   <= 4'd0;
      r_enable    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'd0;
      r_rsp_zero  <= 1'b0;
      r_busy      <= 1'b0;
      r_op_count  <= '0;
`ifdef ALU_OPCHK_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_enable <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_busy <= 1'b1;
`ifdef ALU_OPCHK_EN
            if (!w_op_legal) begin
              // Rejected op: ALU buses untouched, answer straight away.
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= 32'd0;
              r_rsp_zero  <= 1'b0;
              r_state     <= S_RESP;
            end else begin
              r_rsp_err   <= 1'b0;
              r_a_bus     <= bus.cmd_a;
              r_b_bus     <= bus.cmd_b;
              r_control   <= bus.cmd_op;
              r_enable    <= 1'b1;
              r_state     <= S_ISSUE;
            end
`else
            r_a_bus   <= bus.cmd_a;
            r_b_bus   <= bus.cmd_b;
            r_control <= bus.cmd_op;
            r_enable  <= 1'b1;
            r_state   <= S_ISSUE;
`endif
          end
        end

        S_ISSUE: begin
          r_wait_cnt <= c_WAIT_LOAD;
          r_state    <= S_WAIT;
        end

        S_WAIT: begin
          if (r_wait_cnt == c_WAIT_LAST) begin
            r_rsp_data  <= bus.C_bus;
            r_rsp_zero  <= bus.Z_flag;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end

        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_op_count  <= r_op_count + 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.A_bus     = r_a_bus;
  assign bus.B_bus     = r_b_bus;
  assign bus.Control   = r_control;
  assign bus.enable    = r_enable;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_zero  = r_rsp_zero;
  assign bus.busy      = r_busy;
  assign bus.op_count  = r_op_count;

endmodule

`default_nettype wire
